// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder/subtractor.
//   state_t    : control FSM states
//   BCD_MAX    : largest legal BCD digit value
//   BCD_CORR   : decimal correction added to a binary digit sum above BCD_MAX
//   nines_comp : per-digit 9's complement, taken modulo 16 so non-BCD digits stay deterministic
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

   function automatic logic [3:0] nines_comp(input logic [3:0] d);
      // 4-bit subtraction wraps, giving (9 - d) mod 16 for digits above 9
      return BCD_MAX - d;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: a_i + b_i + c_i with BCD correction.
//   a_i, b_i : 4-bit digits (treated as raw binary, so non-BCD digits follow the same rule)
//   c_i      : decimal carry in
//   digit_o  : corrected result digit
//   c_o      : decimal carry out
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] digit_o,
   output logic       c_o
);

   logic [4:0] z;

   always_comb begin
      z = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
      if (z > {1'b0, BCD_MAX}) begin
         // low nibble of z+6; the 4-bit add drops the bit that becomes the carry
         digit_o = z[3:0] + BCD_CORR;
         c_o     = 1'b1;
      end else begin
         digit_o = z[3:0];
         c_o     = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, least significant digit first.
// Subtraction is done as A + 9's complement(B) + ~borrow, so cout=1 means no borrow.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE and out of reset)
//   a, b, cin, sub       : packed BCD operands, carry/borrow in, 0=add 1=subtract
//   out_valid / out_ready: result handshake, result held while out_valid
//   sum, cout, err       : packed BCD result, decimal carry / not-borrow, non-BCD operand flag
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned IDX_W  = $clog2(DIGITS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                cin,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] a_q, a_d;
   logic [4*DIGITS-1:0] b_q, b_d;
   logic                c_q, c_d;
   logic [4*DIGITS-1:0] sum_q, sum_d;
   logic                cout_q, cout_d;
   logic                err_q, err_d;
   logic                err_in_q, err_in_d;

   logic [4*DIGITS-1:0] b_conv;
   logic                raw_err;
   logic [3:0]          dig;
   logic                dig_c;

   // Operand conditioning at accept: complement B for subtract, flag any non-BCD raw digit
   always_comb begin
      b_conv  = '0;
      raw_err = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         b_conv[i*4 +: 4] = sub ? nines_comp(b[i*4 +: 4]) : b[i*4 +: 4];
         raw_err = raw_err | (a[i*4 +: 4] > BCD_MAX) | (b[i*4 +: 4] > BCD_MAX);
      end
   end

   bcd_digit_add u_digit (
      .a_i     (a_q[idx_q*4 +: 4]),
      .b_i     (b_q[idx_q*4 +: 4]),
      .c_i     (c_q),
      .digit_o (dig),
      .c_o     (dig_c)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      err_d    = err_q;
      err_in_d = err_in_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d  = RUN;
               a_d      = a;
               b_d      = b_conv;
               c_d      = sub ? ~cin : cin;
               err_in_d = raw_err;
               idx_d    = '0;
            end
         end
         RUN: begin
            sum_d[idx_q*4 +: 4] = dig;
            c_d    = dig_c;
            cout_d = dig_c;
            // flag captured at accept becomes visible with the first result digit
            err_d  = err_in_q;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         err_q    <= 1'b0;
         err_in_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         err_q    <= err_d;
         err_in_q <= err_in_d;
      end
   end

   assign in_ready  = (state_q == IDLE) & rst_n;
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4 and DIGITS=1 instances).
module tb_bcd_serial_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, err;
   logic [15:0] a, b, sum;

   logic       in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, err1;
   logic [3:0] a1, b1, sum1;

   bcd_serial_addsub #(.DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .err(err)
   );

   bcd_serial_addsub #(.DIGITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .err(err1)
   );

   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        er;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int unsigned v);
      logic [15:0] r;
      int unsigned t;
      r = '0;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Decimal reference: plain integer arithmetic on the operand values
   function automatic void ref_op(input int unsigned av, input int unsigned bv, input bit ci,
                                  input bit sb, output int unsigned s, output bit co);
      int t;
      if (!sb) begin
         t  = int'(av) + int'(bv) + int'(ci);
         co = (t >= 10000);
         s  = int'(t % 10000);
      end else begin
         t  = int'(av) - int'(bv) - int'(ci);
         co = (t >= 0);
         s  = (t < 0) ? int'(t + 10000) : t;
      end
   endfunction

   // One full transaction on the 4-digit instance; lat = cycles from accept edge to out_valid
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                        input logic tsub, output logic [15:0] rs, output logic rc,
                        output logic re, output int lat);
      @(negedge clk);
      chk("in_ready_before_op", {31'b0, in_ready}, 32'd1);
      a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rs = sum; rc = cout; re = err;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [15:0] rs, snap;
   logic        rc, re;
   int          lat;
   int unsigned ra, rb, es;
   bit          rci, rsb, eco;
   logic        ok;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;

      tbl[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
      tbl[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h0999, 16'h0999, 1'b1, 1'b0, 16'h1999, 1'b0, 1'b0};
      tbl[3] = '{16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0};
      tbl[4] = '{16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0};
      tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
      // digit 1 is A: 10+0 > 9 -> (16 mod 16)=0 with carry into digit 2 (2+0+1=3)
      tbl[6] = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h1305, 1'b0, 1'b1};
      tbl[7] = '{16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready_low", {31'b0, in_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("reset_state", {28'b0, in_ready, out_valid, cout, err}, {28'b0, 4'b1000});
      chk("reset_sum", {16'b0, sum}, 32'h0);

      for (int i = 0; i < 8; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rc, re, lat);
         chk($sformatf("tbl%0d_sum", i), {16'b0, rs}, {16'b0, tbl[i].s});
         chk($sformatf("tbl%0d_cout_err", i), {30'b0, rc, re}, {30'b0, tbl[i].co, tbl[i].er});
         chk($sformatf("tbl%0d_latency", i), lat, 32'd4);
      end

      for (int i = 0; i < 30; i++) begin
         ra  = $urandom_range(0, 9999);
         rb  = $urandom_range(0, 9999);
         rci = 1'($urandom_range(0, 1));
         rsb = 1'($urandom_range(0, 1));
         ref_op(ra, rb, rci, rsb, es, eco);
         do_op(to_bcd(ra), to_bcd(rb), rci, rsb, rs, rc, re, lat);
         chk($sformatf("rand%0d_result", i), {14'b0, rc, re, rs}, {14'b0, eco, 1'b0, to_bcd(es)});
         chk($sformatf("rand%0d_latency", i), lat, 32'd4);
      end

      // Back-pressure in DONE: result frozen, new operands ignored
      @(negedge clk);
      a = 16'h2468; b = 16'h1357; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hold_latency", lat, 32'd4);
      a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold_cyc%0d", i), {13'b0, out_valid, in_ready, cout, sum},
             {13'b0, 1'b1, 1'b0, 1'b0, 16'h3826});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hold_release", {14'b0, out_valid, in_ready, sum}, {14'b0, 1'b0, 1'b1, 16'h3826});
      @(posedge clk); #1;
      chk("hold_no_accept", {31'b0, in_ready}, 32'd1);

      // Reset after two RUN digits abandons the operation
      @(negedge clk);
      a = 16'h9876; b = 16'h1234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrun_reset_outs", {13'b0, out_valid, cout, err, sum}, 32'h0);
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) ok = 1'b0;
      end
      chk("midrun_no_out_valid", {31'b0, ok}, 32'd1);
      do_op(16'h4321, 16'h1111, 1'b0, 1'b0, rs, rc, re, lat);
      chk("after_reset_op", {14'b0, rc, re, rs}, {14'b0, 2'b00, 16'h5432});
      chk("after_reset_latency", lat, 32'd4);

      // Single-digit instance: 7+5 -> 2 with carry, one RUN cycle
      @(negedge clk);
      a1 = 4'd7; b1 = 4'd5; cin1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("d1_latency", lat, 32'd1);
      chk("d1_result", {26'b0, cout1, err1, sum1}, {26'b0, 1'b1, 1'b0, 4'd2});
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      chk("d1_release", {30'b0, out_valid1, in_ready1}, 32'd1);

      // Single-digit subtract with borrow: 3-8 -> 5, borrow (cout=0)
      @(negedge clk);
      a1 = 4'd3; b1 = 4'd8; cin1 = 1'b0; sub1 = 1'b1; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      @(posedge clk); #1;
      chk("d1_sub", {26'b0, out_valid1, cout1, sum1}, {26'b0, 1'b1, 1'b0, 4'd5});
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
